uart_alu_link: RTL and testbench

Command sequencer on the FIFO side of the UART. It pulls a three-byte frame (operand A, operand B, opcode) from the UART receive FIFO, presents it on registered ports to a combinational ALU, and captures the result. It then pushes the result byte into the UART transmit FIFO. It sits between the UART top level (rd_uart/rx_empty/r_data, wr_uart/tx_full/w_data) and the ALU.

---
 rtl/uart_alu_link.sv | 92 +++++++++
 tb/tb_uart_alu_link.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_link.sv
// uart_alu_link: pulls A/B/opcode frames from the UART rx FIFO,
// drives a combinational ALU and pushes each result to the tx FIFO.
module uart_alu_link #(
    parameter int DBIT  = 8,
    parameter int NB_OP = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [DBIT-1:0]  r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic [DBIT-1:0]  w_data,
    output logic             wr_uart,
    output logic [DBIT-1:0]  alu_a,
    output logic [DBIT-1:0]  alu_b,
    output logic [NB_OP-1:0] alu_op,
    input  logic [DBIT-1:0]  alu_result,
    output logic             busy
);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        SEND
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DBIT-1:0] res_reg;

    always_comb begin
        state_d = state_q;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        unique case (state_q)
            GET_A: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = GET_OP;
                end
            end
            GET_OP: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = SEND;
            SEND: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    // Captures happen on the same edge the FIFO advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= GET_A;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            res_reg <= '0;
        end else begin
            state_q <= state_d;
            if (rd_uart && state_q == GET_A)
                alu_a <= r_data;
            if (rd_uart && state_q == GET_B)
                alu_b <= r_data;
            if (rd_uart && state_q == GET_OP)
                alu_op <= r_data[NB_OP-1:0];
            if (state_q == EXEC)
                res_reg <= alu_result;
        end
    end

    assign w_data = res_reg;
    assign busy   = (state_q != GET_A);

endmodule

// File: tb/tb_uart_alu_link.sv
// Randomised scoreboard bench for uart_alu_link with FIFO
// models on both UART sides and a behavioural ALU.
module tb_uart_alu_link;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;

    always #5 clk = ~clk;

    uart_alu_link #(.DBIT(8), .NB_OP(6)) dut (
        .clk(clk), .reset(reset),
        .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .busy(busy)
    );

    function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b,
                                         logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    // rx FIFO model: array plus read pointer advanced on pops
    logic [7:0] rx_mem [0:1023];
    int         rx_cnt = 0;
    int         rd_ptr = 0;
    logic       rx_gap;

    assign rx_empty = rx_gap || (rd_ptr >= rx_cnt);
    assign r_data   = rx_mem[rd_ptr[9:0]];

    always @(posedge clk) if (rd_uart) rd_ptr <= rd_ptr + 1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] res;
        logic [5:0] op;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0;
    int n_total = 0;
    bit lat_chk = 1'b0;
    bit sp_chk = 1'b0;
    int last_rd = -100;
    int last_wr = -1;

    task automatic chk(string nm, int act, int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      nm, act, expv, $time);
    endtask

    task automatic push_byte(logic [7:0] v);
        rx_mem[rx_cnt[9:0]] = v;
        rx_cnt++;
    endtask

    task automatic push_frame(logic [7:0] a, logic [7:0] b, logic [7:0] ob);
        exp_t e;
        e.op  = ob[5:0];
        e.res = alu_f(a, b, ob[5:0]);
        push_byte(a);
        push_byte(b);
        push_byte(ob);
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            if (rd_uart) begin
                chk("rd_while_empty", int'(rx_empty), 0);
                last_rd = cyc;
            end
            if (wr_uart) begin
                exp_t e;
                chk("wr_while_full", int'(tx_full), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("w_data", int'(w_data), int'(e.res));
                    chk("alu_op", int'(alu_op), int'(e.op));
                end
                if (lat_chk) chk("wr_latency", cyc - last_rd, 2);
                if (sp_chk && last_wr >= 0) chk("wr_spacing", cyc - last_wr, 5);
                last_wr = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || rd_ptr != rx_cnt) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(n < budget), 1);
    endtask

    task automatic wait_ptr(int target);
        int n = 0;
        while (rd_ptr < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pop_timeout", int'(n < 200), 1);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_alu_a"}, int'(alu_a), 0);
        chk({tag, "_alu_b"}, int'(alu_b), 0);
        chk({tag, "_alu_op"}, int'(alu_op), 0);
        chk({tag, "_w_data"}, int'(w_data), 0);
        chk({tag, "_rd_uart"}, int'(rd_uart), 0);
        chk({tag, "_wr_uart"}, int'(wr_uart), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    logic [5:0] opl [7];
    int         base;

    initial begin
        opl[0] = 6'h20; opl[1] = 6'h22; opl[2] = 6'h24; opl[3] = 6'h25;
        opl[4] = 6'h26; opl[5] = 6'h27; opl[6] = 6'h02;
        reset = 1'b0;
        rx_gap = 1'b0;
        tx_full = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        tick();
        reset = 1'b1;

        // single frame
        lat_chk = 1'b1;
        push_frame(8'h05, 8'h03, 8'h20);
        wait_idle(100);
        chk("single_a", int'(alu_a), 8'h05);
        chk("single_b", int'(alu_b), 8'h03);
        chk("single_op", int'(alu_op), 8'h20);
        chk("single_res", int'(w_data), 8'h08);
        chk("single_busy", int'(busy), 0);

        // opcode masking
        tick();
        push_frame(8'h05, 8'h03, 8'hE0);
        wait_idle(100);
        chk("mask_op", int'(alu_op), 8'h20);
        chk("mask_res", int'(w_data), 8'h08);

        // gapped input
        rx_gap = 1'b1;
        push_frame(8'h30, 8'h12, 8'h22);
        for (int i = 0; i < 3; i++) begin
            rx_gap = 1'b0;
            tick();
            rx_gap = 1'b1;
            for (int j = 0; j < 7; j++) begin
                @(negedge clk);
                chk("gap_rd", int'(rd_uart), 0);
            end
            if (i == 0) chk("gap_keep_a", int'(alu_a), 8'h30);
            if (i == 1) chk("gap_keep_b", int'(alu_b), 8'h12);
            tick();
        end
        rx_gap = 1'b0;
        wait_idle(100);
        chk("gap_res", int'(w_data), 8'h1E);

        // backpressure with next frame queued
        lat_chk = 1'b0;
        tick();
        tx_full = 1'b1;
        base = rd_ptr;
        push_frame(8'h40, 8'h02, 8'h20);
        push_frame(8'h0F, 8'hF0, 8'h25);
        wait_ptr(base + 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rd", int'(rd_uart), 0);
            chk("bp_wr", int'(wr_uart), 0);
        end
        chk("bp_ptr", rd_ptr, base + 3);
        @(posedge clk);
        #1;
        tx_full = 1'b0;
        @(negedge clk);
        chk("bp_release_wr", int'(wr_uart), 1);
        chk("bp_release_data", int'(w_data), 8'h42);
        wait_idle(100);

        // reset mid-frame
        tick();
        base = rd_ptr;
        push_byte(8'h55);
        push_byte(8'h66);
        wait_ptr(base + 2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        tick();
        reset = 1'b1;
        lat_chk = 1'b1;
        push_frame(8'h0A, 8'h01, 8'h20);
        wait_idle(100);
        chk("rst_res", int'(w_data), 8'h0B);
        chk("rst_a", int'(alu_a), 8'h0A);

        // streaming
        tick();
        sp_chk = 1'b1;
        last_wr = -1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] hi;
            hi = 2'($urandom_range(0, 3));
            push_frame(8'($urandom), 8'($urandom),
                       {hi, opl[$urandom_range(0, 6)]});
        end
        wait_idle(100);
        sp_chk = 1'b0;
        lat_chk = 1'b0;

        // random traffic with gaps and backpressure
        begin
            int left = 25;
            for (int c = 0; c < 400; c++) begin
                if (left > 0 && $urandom_range(0, 3) == 0) begin
                    logic [1:0] hi;
                    hi = 2'($urandom_range(0, 3));
                    push_frame(8'($urandom), 8'($urandom),
                               {hi, opl[$urandom_range(0, 6)]});
                    left--;
                end
                rx_gap = ($urandom_range(0, 3) == 0);
                tx_full = ($urandom_range(0, 9) < 3);
                tick();
            end
            rx_gap = 1'b0;
            tx_full = 1'b0;
            wait_idle(500);
        end

        chk("final_queue", exp_q.size(), 0);
        chk("final_ptr", rd_ptr, rx_cnt);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
